// File: rtl/riscv_pkg.sv
// Shared RV32I control types: opcode constants, controller state, datapath select encodings.
package riscv_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        TRAP
    } ctrl_state_t;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2
    } wb_sel_t;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'd0,
        ALU_SUB   = 2'd1,
        ALU_FUNCT = 2'd2
    } alu_op_t;

    // One-hot instruction class; all-zero means the opcode is not supported.
    typedef struct packed {
        logic load;
        logic store;
        logic imm;
        logic alu_r;
        logic branch;
        logic jal;
    } opclass_t;

endpackage

// File: rtl/ctrl_opclass.sv
// Purpose: classify a 7-bit opcode into a one-hot class plus an illegal flag.
// Latency: purely combinational.
// Backpressure: none, no handshake.
module ctrl_opclass
    import riscv_pkg::*;
(
    input  logic [6:0] opcode,
    output opclass_t   cls,
    output logic       illegal
);

    always_comb begin
        cls = '0;
        case (opcode)
            OP_LOAD:   cls.load   = 1'b1;
            OP_STORE:  cls.store  = 1'b1;
            OP_IMM:    cls.imm    = 1'b1;
            OP_REG:    cls.alu_r  = 1'b1;
            OP_BRANCH: cls.branch = 1'b1;
            OP_JAL:    cls.jal    = 1'b1;
            default:   cls        = '0;
        endcase
    end

    assign illegal = (cls == '0);

endmodule

// File: rtl/multicycle_ctrl.sv
// Purpose: multicycle RV32I control FSM driving datapath enables, selects and memory requests.
// Latency: 3-5 cycles per instruction plus one cycle per memory wait cycle; outputs Mealy on ready.
// Backpressure: requests held until ready or MEM_TIMEOUT wait cycles, then bus_err and trap.
module multicycle_ctrl
    import riscv_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic        funct7_5,
    input  logic        br_taken,
    output logic        imem_req,
    input  logic        imem_ready,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ready,
    output logic        ir_we,
    output logic        pc_we,
    output logic        pc_sel,
    output logic        reg_we,
    output logic [1:0]  wb_sel,
    output logic        alu_b_sel,
    output logic [1:0]  alu_op,
    output logic        illegal,
    output logic        bus_err,
    output logic [31:0] instret
);

    ctrl_state_t state, state_nxt;
    opclass_t    cls;
    logic        op_illegal;
    logic [15:0] wait_cnt;
    logic        wait_inc;
    logic        timed_out;
    logic        set_illegal;
    logic        set_bus_err;
    wb_sel_t     wb_sel_e;
    alu_op_t     alu_op_e;

    // funct fields are decoded by the ALU itself when alu_op selects funct decode.
    logic unused_funct;
    assign unused_funct = ^{funct3, funct7_5};

    ctrl_opclass u_opclass (
        .opcode  (opcode),
        .cls     (cls),
        .illegal (op_illegal)
    );

    assign timed_out = (wait_cnt == 16'(MEM_TIMEOUT));
    assign wb_sel    = wb_sel_e;
    assign alu_op    = alu_op_e;

    always_comb begin
        state_nxt   = state;
        imem_req    = 1'b0;
        ir_we       = 1'b0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        pc_we       = 1'b0;
        pc_sel      = 1'b0;
        reg_we      = 1'b0;
        wb_sel_e    = WB_ALU;
        alu_b_sel   = 1'b0;
        alu_op_e    = ALU_ADD;
        wait_inc    = 1'b0;
        set_illegal = 1'b0;
        set_bus_err = 1'b0;
        case (state)
            FETCH: begin
                if (imem_ready) begin
                    imem_req  = 1'b1;
                    ir_we     = 1'b1;
                    state_nxt = DECODE;
                end else if (timed_out) begin
                    set_bus_err = 1'b1;
                    state_nxt   = TRAP;
                end else begin
                    imem_req = 1'b1;
                    wait_inc = 1'b1;
                end
            end
            DECODE: begin
                if (op_illegal) begin
                    set_illegal = 1'b1;
                    state_nxt   = TRAP;
                end else begin
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                if (cls.load || cls.store) begin
                    alu_b_sel = 1'b1;
                    state_nxt = MEM;
                end else if (cls.imm) begin
                    alu_b_sel = 1'b1;
                    alu_op_e  = ALU_FUNCT;
                    state_nxt = WB;
                end else if (cls.alu_r) begin
                    alu_op_e  = ALU_FUNCT;
                    state_nxt = WB;
                end else if (cls.branch) begin
                    alu_op_e  = ALU_SUB;
                    pc_we     = 1'b1;
                    pc_sel    = br_taken;
                    state_nxt = FETCH;
                end else if (cls.jal) begin
                    reg_we    = 1'b1;
                    wb_sel_e  = WB_PC4;
                    pc_we     = 1'b1;
                    pc_sel    = 1'b1;
                    state_nxt = FETCH;
                end else begin
                    set_illegal = 1'b1;
                    state_nxt   = TRAP;
                end
            end
            MEM: begin
                alu_b_sel = 1'b1;
                if (dmem_ready) begin
                    dmem_req = 1'b1;
                    dmem_we  = cls.store;
                    if (cls.store) begin
                        pc_we     = 1'b1;
                        state_nxt = FETCH;
                    end else begin
                        state_nxt = WB;
                    end
                end else if (timed_out) begin
                    set_bus_err = 1'b1;
                    state_nxt   = TRAP;
                end else begin
                    dmem_req = 1'b1;
                    dmem_we  = cls.store;
                    wait_inc = 1'b1;
                end
            end
            WB: begin
                reg_we = 1'b1;
                if (cls.load) begin
                    wb_sel_e = WB_MEM;
                end else begin
                    wb_sel_e = WB_ALU;
                end
                pc_we     = 1'b1;
                state_nxt = FETCH;
            end
            // TRAP and unused encodings all park in TRAP with every strobe low.
            default: state_nxt = TRAP;
        endcase
        // Reset kills any in-flight request or write in the same cycle.
        if (rst) begin
            imem_req  = 1'b0;
            ir_we     = 1'b0;
            dmem_req  = 1'b0;
            dmem_we   = 1'b0;
            pc_we     = 1'b0;
            pc_sel    = 1'b0;
            reg_we    = 1'b0;
            wb_sel_e  = WB_ALU;
            alu_b_sel = 1'b0;
            alu_op_e  = ALU_ADD;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FETCH;
            wait_cnt <= '0;
            illegal  <= 1'b0;
            bus_err  <= 1'b0;
            instret  <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_inc ? wait_cnt + 16'd1 : 16'd0;
            if (set_illegal) begin
                illegal <= 1'b1;
            end
            if (set_bus_err) begin
                bus_err <= 1'b1;
            end
            if (pc_we) begin
                instret <= instret + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: vector table, directed corner cases, random instruction stream.
module tb_multicycle_ctrl;

    localparam int TMO = 4;

    logic        clk;
    logic        rst;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7_5;
    logic        br_taken;
    logic        imem_req;
    logic        imem_ready;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ready;
    logic        ir_we;
    logic        pc_we;
    logic        pc_sel;
    logic        reg_we;
    logic [1:0]  wb_sel;
    logic        alu_b_sel;
    logic [1:0]  alu_op;
    logic        illegal;
    logic        bus_err;
    logic [31:0] instret;

    int nerr = 0;
    int nchk = 0;
    int exp_instret = 0;

    multicycle_ctrl #(.MEM_TIMEOUT(TMO)) dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .funct3     (funct3),
        .funct7_5   (funct7_5),
        .br_taken   (br_taken),
        .imem_req   (imem_req),
        .imem_ready (imem_ready),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_ready (dmem_ready),
        .ir_we      (ir_we),
        .pc_we      (pc_we),
        .pc_sel     (pc_sel),
        .reg_we     (reg_we),
        .wb_sel     (wb_sel),
        .alu_b_sel  (alu_b_sel),
        .alu_op     (alu_op),
        .illegal    (illegal),
        .bus_err    (bus_err),
        .instret    (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected per-instruction summary; -1 marks a don't-care field.
    typedef struct {
        logic [6:0] op;
        logic       br;
        int iw; int dw;
        int cycles; int regwe; int wbsel; int pcsel;
        int dreq; int dwe; int aop; int bsel;
    } vec_t;

    typedef struct {
        int cycles; int ircnt; int ircyc; int pcwe; int pcsel;
        int regwe; int wbsel; int dreq; int dwe; int aop; int bsel;
        int mem_bad; int done;
    } obs_t;

    task automatic chk(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: instruction cost and strobes derived from the instruction class.
    function automatic vec_t model(input logic [6:0] op, input logic br, input int iw, input int dw);
        vec_t v;
        v.op = op; v.br = br; v.iw = iw; v.dw = dw;
        v.regwe = 0; v.wbsel = -1; v.pcsel = 0; v.dreq = 0; v.dwe = 0; v.aop = -1; v.bsel = -1;
        case (op)
            7'b0000011: begin v.cycles = 5 + iw + dw; v.regwe = 1; v.wbsel = 1; v.dreq = dw + 1; v.aop = 0; v.bsel = 1; end
            7'b0100011: begin v.cycles = 4 + iw + dw; v.dreq = dw + 1; v.dwe = 1; v.aop = 0; v.bsel = 1; end
            7'b0010011: begin v.cycles = 4 + iw; v.regwe = 1; v.wbsel = 0; v.aop = 2; v.bsel = 1; end
            7'b0110011: begin v.cycles = 4 + iw; v.regwe = 1; v.wbsel = 0; v.aop = 2; v.bsel = 0; end
            7'b1100011: begin v.cycles = 3 + iw; v.pcsel = int'(br); v.aop = 1; end
            default:    begin v.cycles = 3 + iw; v.regwe = 1; v.wbsel = 2; v.pcsel = 1; end
        endcase
        return v;
    endfunction

    // Called at a negedge; fetch ready after iw wait cycles, data ready after dw wait cycles.
    task automatic run_instr(input logic [6:0] op, input logic br, input int iw, input int dw, output obs_t o);
        int  cyc;
        bit  is_mem;
        o = '{default: 0};
        o.wbsel = -1; o.pcsel = -1; o.aop = -1; o.bsel = -1;
        is_mem = (op == 7'b0000011) || (op == 7'b0100011);
        opcode = op;
        br_taken = br;
        cyc = 0;
        while (o.done == 0 && cyc < 64) begin
            imem_ready = (cyc == iw);
            dmem_ready = is_mem && (cyc == iw + 3 + dw);
            funct3 = 3'($urandom_range(0, 7));
            funct7_5 = 1'($urandom_range(0, 1));
            #1;
            if (ir_we) begin o.ircnt++; o.ircyc = cyc + 1; end
            if (cyc == iw + 2) begin o.aop = int'(alu_op); o.bsel = int'(alu_b_sel); end
            if (dmem_req) begin
                o.dreq++;
                if (dmem_we) o.dwe = 1;
                if (!(alu_b_sel && alu_op == 2'd0)) o.mem_bad = 1;
            end
            if (reg_we) begin o.regwe++; o.wbsel = int'(wb_sel); end
            if (pc_we) begin o.pcwe++; o.pcsel = int'(pc_sel); o.done = 1; end
            cyc++;
            @(negedge clk);
        end
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        o.cycles = cyc;
    endtask

    task automatic apply(input vec_t v, input string tag);
        obs_t o;
        run_instr(v.op, v.br, v.iw, v.dw, o);
        exp_instret++;
        chk({tag, ".done"}, o.done, 1);
        chk({tag, ".cycles"}, o.cycles, v.cycles);
        chk({tag, ".ir_we_cnt"}, o.ircnt, 1);
        chk({tag, ".ir_we_cycle"}, o.ircyc, v.iw + 1);
        chk({tag, ".pc_we_cnt"}, o.pcwe, 1);
        chk({tag, ".pc_sel"}, o.pcsel, v.pcsel);
        chk({tag, ".reg_we_cnt"}, o.regwe, v.regwe);
        if (v.wbsel >= 0) chk({tag, ".wb_sel"}, o.wbsel, v.wbsel);
        chk({tag, ".dmem_req_cycles"}, o.dreq, v.dreq);
        chk({tag, ".dmem_we"}, o.dwe, v.dwe);
        if (v.aop >= 0) chk({tag, ".exec_alu_op"}, o.aop, v.aop);
        if (v.bsel >= 0) chk({tag, ".exec_alu_b_sel"}, o.bsel, v.bsel);
        chk({tag, ".mem_addr_sel"}, o.mem_bad, 0);
        chk({tag, ".instret"}, int'(instret), exp_instret);
        chk({tag, ".flags"}, int'({illegal, bus_err}), 0);
    endtask

    // Runs ncyc cycles with memory that never completes (except an optional first-cycle fetch).
    task automatic run_stuck(input logic [6:0] op, input bit fetch_ok, input int ncyc,
                             output int ireq_n, output int dreq_n, output int strobes);
        ireq_n = 0; dreq_n = 0; strobes = 0;
        opcode = op;
        for (int c = 0; c < ncyc; c++) begin
            imem_ready = fetch_ok && (c == 0);
            dmem_ready = 1'b0;
            #1;
            if (imem_req) ireq_n++;
            if (dmem_req) dreq_n++;
            if (pc_we || reg_we) strobes++;
            @(negedge clk);
        end
        imem_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        exp_instret = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    vec_t       tbl [11];
    logic [6:0] optab [6];
    vec_t       rv;
    int         ir_n, dr_n, st_n;

    initial begin
        tbl[0]  = '{7'b0010011, 1'b0, 0, 0, 4, 1,  0, 0, 0, 0,  2,  1};  // ADDI
        tbl[1]  = '{7'b0000011, 1'b0, 0, 3, 8, 1,  1, 0, 4, 0,  0,  1};  // LW, 3 data waits
        tbl[2]  = '{7'b0100011, 1'b0, 0, 0, 4, 0, -1, 0, 1, 1,  0,  1};  // SW
        tbl[3]  = '{7'b1100011, 1'b1, 0, 0, 3, 0, -1, 1, 0, 0,  1, -1};  // BEQ taken
        tbl[4]  = '{7'b1100011, 1'b0, 0, 0, 3, 0, -1, 0, 0, 0,  1, -1};  // BEQ not taken
        tbl[5]  = '{7'b1101111, 1'b0, 0, 0, 3, 1,  2, 1, 0, 0, -1, -1};  // JAL
        tbl[6]  = '{7'b0110011, 1'b0, 2, 0, 6, 1,  0, 0, 0, 0,  2,  0};  // ADD, 2 fetch waits
        tbl[7]  = '{7'b0100011, 1'b0, 0, 4, 8, 0, -1, 0, 5, 1,  0,  1};  // SW, ready at timeout
        tbl[8]  = '{7'b0000011, 1'b0, 4, 0, 9, 1,  1, 0, 1, 0,  0,  1};  // LW, fetch ready at timeout
        tbl[9]  = '{7'b0000011, 1'b0, 0, 0, 5, 1,  1, 0, 1, 0,  0,  1};  // LW zero wait
        tbl[10] = '{7'b1100011, 1'b1, 1, 0, 4, 0, -1, 1, 0, 0,  1, -1};  // BEQ, 1 fetch wait
        optab[0] = 7'b0000011; optab[1] = 7'b0100011; optab[2] = 7'b0010011;
        optab[3] = 7'b0110011; optab[4] = 7'b1100011; optab[5] = 7'b1101111;

        rst = 1'b1; opcode = 7'b1101111; funct3 = 3'd0; funct7_5 = 1'b0;
        br_taken = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("reset.strobes", int'({imem_req, ir_we, dmem_req, dmem_we, pc_we, pc_sel, reg_we,
                                   wb_sel, alu_b_sel, alu_op}), 0);
        chk("reset.instret", int'(instret), 0);
        chk("reset.flags", int'({illegal, bus_err}), 0);
        imem_ready = 1'b0; dmem_ready = 1'b0; rst = 1'b0;
        #1;
        chk("reset.fetch_req", int'(imem_req), 1);

        foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

        // Reset in MEM of a store while dmem_ready is high: no pc_we, instret cleared.
        opcode = 7'b0100011; imem_ready = 1'b1;
        #1;
        chk("rstmem.ir_we", int'(ir_we), 1);
        @(negedge clk); imem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rstmem.in_mem", int'(dmem_req), 1);
        rst = 1'b1; dmem_ready = 1'b1;
        #1;
        chk("rstmem.pc_we", int'(pc_we), 0);
        chk("rstmem.dmem_req", int'(dmem_req), 0);
        @(negedge clk);
        rst = 1'b0; dmem_ready = 1'b0; exp_instret = 0;
        #1;
        chk("rstmem.instret", int'(instret), 0);
        chk("rstmem.fetch_req", int'(imem_req), 1);

        for (int i = 0; i < 150; i++) begin
            rv = model(optab[$urandom_range(0, 5)], 1'($urandom_range(0, 1)),
                       int'($urandom_range(0, TMO)), int'($urandom_range(0, TMO)));
            apply(rv, $sformatf("rand%0d", i));
        end

        // Illegal opcode traps and stays quiet for 100 cycles.
        do_reset();
        run_stuck(7'h7F, 1'b1, 101, ir_n, dr_n, st_n);
        chk("illegal.imem_req_cycles", ir_n, 1);
        chk("illegal.dmem_req_cycles", dr_n, 0);
        chk("illegal.strobes", st_n, 0);
        chk("illegal.flag", int'(illegal), 1);
        chk("illegal.bus_err", int'(bus_err), 0);
        chk("illegal.instret", int'(instret), 0);
        do_reset();
        #1;
        chk("illegal.cleared", int'(illegal), 0);
        chk("illegal.fetch_after_rst", int'(imem_req), 1);
        @(negedge clk);

        // Fetch never ready: request held for TMO cycles, then bus error.
        do_reset();
        run_stuck(7'b0010011, 1'b0, 15, ir_n, dr_n, st_n);
        chk("ftmo.imem_req_cycles", ir_n, TMO);
        chk("ftmo.strobes", st_n, 0);
        chk("ftmo.bus_err", int'(bus_err), 1);
        chk("ftmo.illegal", int'(illegal), 0);

        // Load data never ready: dmem_req held for TMO cycles, then bus error.
        do_reset();
        #1;
        chk("dtmo.bus_err_cleared", int'(bus_err), 0);
        run_stuck(7'b0000011, 1'b1, 20, ir_n, dr_n, st_n);
        chk("dtmo.imem_req_cycles", ir_n, 1);
        chk("dtmo.dmem_req_cycles", dr_n, TMO);
        chk("dtmo.strobes", st_n, 0);
        chk("dtmo.bus_err", int'(bus_err), 1);
        chk("dtmo.instret", int'(instret), 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multicycle control FSM for the RV32I core: fetch, decode, execute, memory access and writeback over several cycles, using one ALU, one immediate generator and one memory port each for instructions and data. It reads the opcode and funct fields from the registered instruction and drives all datapath enables and mux selects. The immediate generator decodes the opcode itself, so this block never selects an immediate format. It also handles memory ready/timeout handshakes, illegal opcodes and the retired-instruction count.

## Interface
- MEM_TIMEOUT, default 255: maximum wait cycles for imem_ready/dmem_ready before a bus error (1..65535).
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- opcode  in  7  IR[6:0], from the registered instruction.
- funct3  in  3  IR[14:12].
- funct7_5  in  1  IR[30].
- br_taken  in  1  branch comparator result for the current funct3; 1 = taken.
- imem_req  out  1  instruction fetch request.
- imem_ready  in  1  fetch data valid this cycle.
- dmem_req  out  1  data access request.
- dmem_we  out  1  1 = store, 0 = load; valid while dmem_req = 1.
- dmem_ready  in  1  data access complete this cycle.
- ir_we  out  1  write the instruction register.
- pc_we  out  1  write the PC.
- pc_sel  out  1  0 = PC+4, 1 = PC+imm.
- reg_we  out  1  register file write enable.
- wb_sel  out  2  writeback source: 0 = ALU, 1 = load data, 2 = PC+4.
- alu_b_sel  out  1  ALU B operand: 0 = rs2, 1 = imm.
- alu_op  out  2  0 = ADD, 1 = SUB/compare, 2 = decode from funct3/funct7_5.
- illegal  out  1  sticky: illegal opcode trapped.
- bus_err  out  1  sticky: memory handshake timeout.
- instret  out  32  retired-instruction counter.

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP. Reset state: FETCH.
- Every output is 0 after reset, including instret, illegal and bus_err.
- FETCH:
  - Assert imem_req. It stays high until imem_ready.
  - On imem_ready: ir_we = 1 for exactly that cycle, then go to DECODE.
- DECODE (1 cycle, no strobes):
  - Legal opcodes: 0000011 load, 0100011 store, 0010011 I-ALU, 0110011 R-ALU, 1100011 branch, 1101111 JAL. All go to EXEC.
  - Any other opcode: go to TRAP and set illegal.
- EXEC:
  - Load/store: alu_b_sel = 1, alu_op = 0. Go to MEM.
  - I-ALU: alu_b_sel = 1, alu_op = 2. Go to WB.
  - R-ALU: alu_b_sel = 0, alu_op = 2. Go to WB.
  - Branch: alu_op = 1, pc_we = 1, pc_sel = br_taken. Go to FETCH.
  - JAL: reg_we = 1, wb_sel = 2, pc_we = 1, pc_sel = 1. Go to FETCH.
- MEM:
  - dmem_req = 1; dmem_we = 1 for stores. Address operands stay held: alu_b_sel = 1, alu_op = 0.
  - Store, on dmem_ready: pc_we = 1, pc_sel = 0. Go to FETCH.
  - Load, on dmem_ready: go to WB.
- WB:
  - reg_we = 1; wb_sel = 1 for loads, 0 for ALU ops.
  - pc_we = 1, pc_sel = 0. Go to FETCH.
- Strobe rule: ir_we, pc_we, reg_we and dmem_req are only asserted in the states listed above and are never high in TRAP.
- TRAP: absorbing state. All strobes 0. Left only through rst.
- instret increments by 1 in each cycle where pc_we = 1, wrapping from 0xFFFFFFFF to 0.
- Wait counter:
  - 16-bit; cleared on entry to FETCH or MEM; increments each cycle the request is held without ready.
  - When it reaches MEM_TIMEOUT with ready still low: drop the request, set bus_err, go to TRAP.
  - Ready arriving in the same cycle the counter reaches MEM_TIMEOUT counts as success.

## Timing
- Outputs are combinational from the state register plus opcode and ready inputs (Mealy on ready). All state, counters and flags are registered.
- Cycles per instruction with zero-wait memory (ready high in the first request cycle):
  - ALU: 4 (FETCH, DECODE, EXEC, WB).
  - Load: 5.
  - Store: 4.
  - Branch and JAL: 3.
- Each cycle of memory wait adds exactly one cycle.
- rst mid-operation: FETCH on the next edge. Any outstanding request is dropped that cycle, with no write strobe. illegal, bus_err and instret clear.
- rst has priority over every transition, including a ready arriving in the same cycle.

## Structure
- Package riscv_pkg holds:
  - Opcode constants: OP_LOAD, OP_STORE, OP_IMM, OP_REG, OP_BRANCH, OP_JAL.
  - State enum ctrl_state_t.
  - wb_sel_t and alu_op_t enums.
- One sub-module, ctrl_opclass: combinational classification of opcode into a one-hot class plus an illegal bit. It is shared with the future hazard/trap logic.

## Test plan
- ADDI (0x00500093), zero-wait memory: ir_we at cycle 1; reg_we with wb_sel = 0 and pc_we at cycle 4; instret = 1.
- LW (opcode 0000011), dmem_ready delayed 3 cycles: dmem_req held for 4 cycles with dmem_we = 0; then WB with wb_sel = 1; 8 cycles total.
- BEQ with br_taken = 1, then = 0: pc_we in EXEC with pc_sel = 1, then pc_sel = 0; reg_we never asserted; 3 cycles each.
- Opcode 0x7F: DECODE goes to TRAP; illegal = 1; pc_we, reg_we and imem_req stay 0 for 100 cycles; rst returns to FETCH with illegal = 0.
- MEM_TIMEOUT = 4, imem_ready stuck low: imem_req drops after 4 wait cycles; bus_err = 1; TRAP. Repeat with ready arriving on the 4th wait cycle: success, no bus_err.
- rst asserted in MEM during a store with dmem_ready = 1 in the same cycle: no pc_we; next state FETCH; instret = 0.
